quantdeser: RTL and testbench

Bit-serial deserializer directly downstream of the quantizer/serializer. It captures the MSB-first serial stream the serializer emits after each `start`, reassembles it into a right-aligned parallel word of programmable precision, optionally sign-extends it, and buffers it in a small output FIFO behind a valid/ready handshake for the writeback path.

---
 rtl/quantdeser_pkg.sv | 12 +
 rtl/quantdeser_fifo.sv | 59 +++++
 rtl/quantdeser.sv | 107 ++++++++++
 tb/tb_quantdeser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/quantdeser_pkg.sv
// Shared definitions for the quantizer deserializer: FSM state encoding and
// the default output precision shared with the serializer.
package quantdeser_pkg;

    localparam int QD_BDOUTMAX = 32;

    typedef enum logic {
        QD_IDLE  = 1'b0,
        QD_SHIFT = 1'b1
    } qd_state_e;

endpackage

// File: rtl/quantdeser_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head. The head is
// forced to zero while empty so the consumer never sees stale storage.
module quantdeser_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign doPush = push && (!full || doPop);
    assign head   = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/quantdeser.sv
// Bit-serial deserializer: captures an MSB-first stream after each start,
// right-aligns and sign/zero-extends it, and queues the word for writeback.
module quantdeser
    import quantdeser_pkg::*;
#(
    parameter int BDOUTMAX = QD_BDOUTMAX,
    parameter int DEPTH    = 2,
    localparam int MAXBDOP = $clog2(BDOUTMAX)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [MAXBDOP-1:0]  bdout,
    input  logic                sext,
    input  logic                start,
    input  logic                din,
    output logic [BDOUTMAX-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                ovf
);

    qd_state_e           state;
    logic [MAXBDOP-1:0]  len;
    logic [MAXBDOP-1:0]  cnt;
    logic                sx;
    logic [BDOUTMAX-1:0] acc;
    logic [BDOUTMAX-1:0] nextAcc;
    logic [BDOUTMAX-1:0] pushWord;
    logic                pushNow;
    logic                popNow;
    logic                fifoFull;
    logic                fifoEmpty;

    assign pushNow    = (state == QD_SHIFT) && (cnt == '0);
    assign popNow     = dout_valid && dout_ready;
    assign dout_valid = !fifoEmpty;

    // The final bit is folded in here so the push needs no extra cycle.
    always_comb begin
        nextAcc  = {acc[BDOUTMAX-2:0], din};
        pushWord = '0;
        for (int i = 0; i < BDOUTMAX; i++) begin
            if (i <= int'(len)) begin
                pushWord[i] = nextAcc[i];
            end else begin
                pushWord[i] = sx & nextAcc[len];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= QD_IDLE;
            busy  <= 1'b0;
            len   <= '0;
            sx    <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                QD_IDLE: begin
                    if (start) begin
                        len   <= bdout;
                        sx    <= sext;
                        cnt   <= bdout;
                        acc   <= '0;
                        state <= QD_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                QD_SHIFT: begin
                    acc <= nextAcc;
                    if (cnt != '0) begin
                        cnt <= cnt - MAXBDOP'(1);
                    end else begin
                        state <= QD_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= QD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (pushNow && fifoFull && !popNow) begin
                ovf <= 1'b1;
            end
        end
    end

    quantdeser_fifo #(
        .WIDTH (BDOUTMAX),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (pushNow),
        .pop   (popNow),
        .wdata (pushWord),
        .head  (dout),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

endmodule

// File: tb/tb_quantdeser.sv
// Scoreboard bench for quantdeser: expected words are queued as each serial
// word is driven and compared whenever the DUT hands a word over.
module tb_quantdeser;

    localparam int W  = 32;
    localparam int BW = $clog2(W);

    logic          clk = 1'b0;
    logic          clr;
    logic [BW-1:0] bdout;
    logic          sext;
    logic          start;
    logic          din;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          ovf;

    int            checkCount = 0;
    int            errorCount = 0;
    logic [W-1:0]  expQ[$];

    quantdeser #(
        .BDOUTMAX (W),
        .DEPTH    (2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .bdout      (bdout),
        .sext       (sext),
        .start      (start),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] expectedWord(input int len, input bit sx, input logic [W-1:0] bits);
        logic [63:0] m;
        logic [W-1:0] mask;
        logic [W-1:0] v;
        m    = (64'd1 << (len + 1)) - 64'd1;
        mask = m[W-1:0];
        v    = bits & mask;
        if (sx && bits[len]) v = v | ~mask;
        return v;
    endfunction

    // Scoreboard side: every accepted handshake must match the oldest queued word.
    initial begin
        forever begin
            @(negedge clk);
            if (dout_valid && dout_ready && !clr) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousValid", {31'b0, dout_valid}, 32'd0);
                end else begin
                    checkOutput("popWord", dout, expQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input int len, input bit sx, input logic [W-1:0] bits,
                                 input bit expectPush, input bit checkTiming,
                                 input bit noisyStart, input bit readyOnLast);
        bdout = BW'(len);
        sext  = sx;
        start = 1'b1;
        din   = 1'b0;
        if (expectPush) expQ.push_back(expectedWord(len, sx, bits));
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busyStart", {31'b0, busy}, 32'd1);
        if (checkTiming) checkOutput("validEarly", {31'b0, dout_valid}, 32'd0);
        for (int i = len; i >= 0; i--) begin
            din = bits[i];
            if (noisyStart) start = (i % 2 == 1);
            if (readyOnLast && i == 0) dout_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (i > 0) begin
                checkOutput("busyMid", {31'b0, busy}, 32'd1);
                if (checkTiming) checkOutput("validEarly", {31'b0, dout_valid}, 32'd0);
            end
        end
        checkOutput("busyEnd", {31'b0, busy}, 32'd0);
        if (checkTiming) checkOutput("validRise", {31'b0, dout_valid}, 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
        @(posedge clk); #1;
        checkOutput("validIdle", {31'b0, dout_valid}, 32'd0);
    endtask

    initial begin
        clr        = 1'b1;
        bdout      = '0;
        sext       = 1'b0;
        start      = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("rstDout", dout, 32'd0);
        checkOutput("rstValid", {31'b0, dout_valid}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstOvf", {31'b0, ovf}, 32'd0);

        // Latency of bdout+2 edges into an empty FIFO, then the zero-extended word.
        applyStimulus(3, 1'b0, 32'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("headB", dout, 32'h0000000B);
        dout_ready = 1'b1;
        waitDrain(20);

        // Back-to-back words: sign extension, zero extension, 1-bit word.
        applyStimulus(3, 1'b1, 32'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 32'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 32'b1,    1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 32'b1,    1'b1, 1'b0, 1'b0, 1'b0);
        waitDrain(20);

        // Start pulses while shifting must be ignored.
        applyStimulus(7, 1'b0, 32'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("noExtraBusy", {31'b0, busy}, 32'd0);
        waitDrain(20);

        // Overflow: three words into a depth-2 FIFO with no consumer.
        dout_ready = 1'b0;
        applyStimulus(1, 1'b0, 32'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 32'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ovfBeforeDrop", {31'b0, ovf}, 32'd0);
        applyStimulus(1, 1'b0, 32'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovfSet", {31'b0, ovf}, 32'd1);
        checkOutput("holdHead", dout, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("holdHeadLater", dout, 32'd1);
        checkOutput("holdValid", {31'b0, dout_valid}, 32'd1);
        dout_ready = 1'b1;
        waitDrain(20);
        checkOutput("ovfSticky", {31'b0, ovf}, 32'd1);

        // Reset mid-shift with a word parked in the FIFO.
        dout_ready = 1'b0;
        applyStimulus(3, 1'b1, 32'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        bdout = BW'(7);
        sext  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 1'b1;
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        expQ.delete();
        checkOutput("clrBusy", {31'b0, busy}, 32'd0);
        checkOutput("clrValid", {31'b0, dout_valid}, 32'd0);
        checkOutput("clrDout", dout, 32'd0);
        checkOutput("clrOvf", {31'b0, ovf}, 32'd0);
        dout_ready = 1'b1;
        applyStimulus(4, 1'b1, 32'b10011, 1'b1, 1'b1, 1'b0, 1'b0);
        waitDrain(20);

        // Full FIFO with a pop on the same edge as the push: nothing is dropped.
        dout_ready = 1'b0;
        applyStimulus(2, 1'b0, 32'b101, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 32'b011, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 32'b110, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ovfNoDrop", {31'b0, ovf}, 32'd0);
        waitDrain(20);
        checkOutput("ovfStillClear", {31'b0, ovf}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
